// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and defaults for the iterative multiply/divide unit
package mdu_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ITER_DEF = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

    // LO value written on divide-by-zero; HI carries the raw dividend
    localparam logic [XLEN_DEF-1:0] MDU_DIV0_LO = '1;

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - issue/stall/HI-LO write interface between pipeline and multiply/divide unit
interface mdu_iter_if #(
    parameter int XLEN = 32
);
    logic                start;
    logic [1:0]          op;
    logic [XLEN-1:0]     busA;
    logic [XLEN-1:0]     busB;
    logic                flush;
    logic                hilo_rd;
    logic                busy;
    logic                stall;
    logic                multWe;
    logic [2*XLEN-1:0]   busmult;

    modport master (
        output start, op, busA, busB, flush, hilo_rd,
        input  busy, stall, multWe, busmult
    );

    modport slave (
        input  start, op, busA, busB, flush, hilo_rd,
        output busy, stall, multWe, busmult
    );
endinterface

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-division step, MSB of quotient register shifted in
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);
    logic [XLEN:0] diff;

    // The shifted remainder is < 2*divisor, so XLEN+1 bits hold it and diff[XLEN] is the borrow.
    always_comb begin
        diff  = {rem_i, quo_i[XLEN-1]} - {1'b0, div_i};
        rem_o = diff[XLEN] ? {rem_i[XLEN-2:0], quo_i[XLEN-1]} : diff[XLEN-1:0];
        quo_o = {quo_i[XLEN-2:0], ~diff[XLEN]};
    end
endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative shift-add multiply / restoring divide; MDU_FAST_MULT_EN selects single-cycle multiply
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ITER = ITER_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mdu_iter_if.slave    bus
);
    localparam int CW = $clog2(ITER);

    mdu_state_e          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    mdu_op_e             op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_a_q, neg_a_d;

    logic                in_signed, in_is_div, sa, sb, is_div_q;
    logic [XLEN-1:0]     abs_a, abs_b, raw_a;
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, result;
    logic [XLEN-1:0]     div_rem, div_quo, hi_acc, lo_acc;

    assign in_signed = (bus.op == MDU_MULT) || (bus.op == MDU_DIV);
    assign in_is_div = (bus.op == MDU_DIV)  || (bus.op == MDU_DIVU);
    assign sa        = in_signed & bus.busA[XLEN-1];
    assign sb        = in_signed & bus.busB[XLEN-1];
    assign abs_a     = sa ? -bus.busA : bus.busA;
    assign abs_b     = sb ? -bus.busB : bus.busB;
    assign is_div_q  = (op_q == MDU_DIV) || (op_q == MDU_DIVU);
    assign hi_acc    = acc_q[2*XLEN-1:XLEN];
    assign lo_acc    = acc_q[XLEN-1:0];
    assign raw_a     = neg_a_q ? -a_q : a_q;

    // Multiply: {HI,LO} starts as {0, multiplier}; add multiplicand into HI on LSB, shift right.
    assign mul_sum  = {1'b0, hi_acc} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i (hi_acc),
        .quo_i (lo_acc),
        .div_i (b_q),
        .rem_o (div_rem),
        .quo_o (div_quo)
    );

    always_comb begin
        result = neg_res_q ? -acc_q : acc_q;
        if (is_div_q) begin
            if (b_q == '0) begin
                result = {raw_a, XLEN'(MDU_DIV0_LO)};
            end else begin
                result = {(neg_a_q ? -hi_acc : hi_acc), (neg_res_q ? -lo_acc : lo_acc)};
            end
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.multWe  = (state_q == DONE);
    assign bus.busmult = bus.multWe ? result : '0;
    assign bus.stall   = bus.busy & (bus.hilo_rd | bus.start);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_res_d = neg_res_q;
        neg_a_d   = neg_a_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d      = mdu_op_e'(bus.op);
                    a_d       = abs_a;
                    b_d       = abs_b;
                    neg_res_d = sa ^ sb;
                    neg_a_d   = sa;
                    cnt_d     = '0;
                    acc_d     = in_is_div ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
                    state_d   = CALC;
`ifdef MDU_FAST_MULT_EN
                    if (!in_is_div) begin
                        acc_d   = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                acc_d = is_div_q ? {div_rem, div_quo} : mul_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ITER - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= MDU_MULT;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_res_q <= 1'b0;
            neg_a_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_res_q <= neg_res_d;
            neg_a_q   <= neg_a_d;
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed vector bench for mdu_iter; MDU_FAST_MULT_EN shortens expected multiply latency
module tb_mdu_iter;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mdu_iter_if #(.XLEN(32)) bus ();

    mdu_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input string nm);
        int lat;
        int we_cnt;
        int we_at;
        int bad_busy;
        logic [63:0] got;
        lat = 33;
`ifdef MDU_FAST_MULT_EN
        if (!op[1]) lat = 1;
`endif
        we_cnt = 0; we_at = 0; bad_busy = 0; got = '0;
        bus.start = 1'b1; bus.op = op; bus.busA = a; bus.busB = b;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.busA  = $urandom;
                bus.busB  = $urandom;
            end
            #1;
            if (bus.multWe) begin
                we_cnt++;
                we_at = k;
                got   = bus.busmult;
            end
            if (bus.busy !== (k <= lat)) bad_busy++;
        end
        chk({nm, "_we_cycle"}, (we_cnt == 1) ? we_at : 0, lat);
        chk({nm, "_busy"}, bad_busy, 0);
        chk({nm, "_result"}, got, exp);
    endtask

    initial begin
        int we_cnt;
        int lat;
        checks = 0;
        errors = 0;
        vecs[0]  = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[3]  = '{2'b11, 32'd100,       32'd7,         64'h0000_0002_0000_000E};
        vecs[4]  = '{2'b10, 32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF};
        vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000};
        vecs[6]  = '{2'b00, 32'd6,         32'd7,         64'd42};
        vecs[7]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD};
        vecs[8]  = '{2'b11, 32'hFFFF_FFFF, 32'd0,         64'hFFFF_FFFF_FFFF_FFFF};
        vecs[9]  = '{2'b10, 32'hFFFF_FFF8, 32'd0,         64'hFFFF_FFF8_FFFF_FFFF};
        vecs[10] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
        vecs[11] = '{2'b01, 32'h8000_0000, 32'd2,         64'h0000_0001_0000_0000};

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.busA = '0; bus.busB = '0;
        bus.flush = 1'b0; bus.hilo_rd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_busy", bus.busy, 0);
        chk("reset_multWe", bus.multWe, 0);
        chk("reset_busmult", bus.busmult, 0);
        chk("reset_stall", bus.stall, 0);

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Hazard: hilo_rd from T+5, a stray start at T+10 must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.busA = 32'd100; bus.busB = 32'd7;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            bus.start   = (k == 10);
            bus.hilo_rd = (k >= 5);
            if (k == 10) begin
                bus.op = 2'b00; bus.busA = 32'd9; bus.busB = 32'd9;
            end
            #1;
            if (k >= 5) chk($sformatf("haz_stall_k%0d", k), bus.stall, (k <= 33));
            if (k == 33) chk("haz_result", {bus.multWe, bus.busmult}, {1'b1, 64'h0000_0002_0000_000E});
            if (k == 34) chk("haz_idle", {bus.busy, bus.multWe}, 2'b00);
        end
        bus.hilo_rd = 1'b0;

        // Back-to-back: start in T+34 is accepted
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.busA = 32'd50; bus.busB = 32'd5;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
        end
        chk("b2b_free_at_34", bus.busy, 0);
        bus.start = 1'b1; bus.op = 2'b11; bus.busA = 32'd9; bus.busB = 32'd3;
        we_cnt = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (k == 1) chk("b2b_accepted", bus.busy, 1);
            if (k == 33) chk("b2b_result", {bus.multWe, bus.busmult}, {1'b1, 64'h0000_0000_0000_0003});
        end

        // Flush at T+12
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b11; bus.busA = 32'd100; bus.busB = 32'd7;
        we_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            bus.flush = (k == 12);
            #1;
            if (bus.multWe) we_cnt++;
            if (k == 12) chk("flush_busy_before", bus.busy, 1);
            if (k == 13) chk("flush_busy_after", bus.busy, 0);
        end
        chk("flush_no_we", we_cnt, 0);

        // Reset at T+20
        bus.start = 1'b1; bus.op = 2'b10; bus.busA = 32'hFFFF_FFF9; bus.busB = 32'd2;
        we_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst = (k == 20);
            #1;
            if (bus.multWe) we_cnt++;
            if (k == 21) chk("rst_outputs", {bus.busy, bus.stall, bus.multWe, bus.busmult}, '0);
        end
        chk("rst_no_we", we_cnt, 0);

        // Flush and start together in IDLE: flush wins
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00; bus.busA = 32'd6; bus.busB = 32'd7;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        chk("flush_beats_start", bus.busy, 0);

        lat = 33;
`ifdef MDU_FAST_MULT_EN
        lat = 1;
`endif
        run_op(2'b00, 32'd6, 32'd7, 64'd42, $sformatf("mult6x7_lat%0d", lat));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
